alu_seq_display: RTL and testbench

- Parametrised, clocked successor to the 4-bit combinational ALU_top.
- Accepts operand pairs through a start/busy/done handshake.
- Performs add, subtract or multi-cycle shift-add multiply, signed or unsigned.
- Registers the result and flags, and drives NUM_DIGITS active-low seven-segment digits with the result in hex plus a sign digit.

---
 rtl/alu_seq_display.sv | 110 +++++++++++
 tb/tb_alu_seq_display.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_display.sv
// alu_seq_display: sequential add/sub/shift-add multiply ALU with registered result and hex seven-segment display
module alu_seq_display #(
   parameter int WIDTH      = 8,
   parameter int NUM_DIGITS = 6
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [WIDTH-1:0]                 op1,
   input  logic [WIDTH-1:0]                 op2,
   input  logic [1:0]                       operation,
   input  logic                             sign,
   output logic                             busy,
   output logic                             done,
   output logic [2*WIDTH-1:0]               result,
   output logic                             overflow,
   output logic                             error,
   output logic [0:NUM_DIGITS-1][7:0]       displayBits
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [0:15][7:0] SEG = {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   typedef enum logic [1:0] {IDLE, CALC, MUL, DONE} state_t;
   typedef logic [0:NUM_DIGITS-1][7:0] disp_t;
   state_t                r_state, w_next;
   logic [WIDTH-1:0]      r_a, r_b, r_mplier, w_m1, w_m2, w_low;
   logic [1:0]            r_op;
   logic                  r_sign, r_neg, w_last, w_fin, w_sovf, w_ovf, w_err;
   logic [CW-1:0]         r_cnt;
   logic [2*WIDTH-1:0]    r_acc, r_mcand, w_pp, w_prod, w_res;
   logic [WIDTH:0]        w_addsub;
   function automatic disp_t disp(input logic [2*WIDTH-1:0] r, input logic s);
      disp = {NUM_DIGITS{8'hFF}};
      for (int i = 0; i < WIDTH/2; i++) disp[i] = SEG[r[4*i +: 4]];
      disp[NUM_DIGITS-1] = (s && r[2*WIDTH-1]) ? 8'hBF : 8'hFF;
   endfunction
   assign busy     = r_state != IDLE;
   assign done     = r_state == DONE;
   assign w_last   = r_cnt == CW'(WIDTH - 1);
   assign w_fin    = (r_state == CALC) || (r_state == MUL && w_last);
   assign w_m1     = (sign && op1[WIDTH-1]) ? -op1 : op1;
   assign w_m2     = (sign && op2[WIDTH-1]) ? -op2 : op2;
   assign w_pp     = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_prod   = r_neg ? -w_pp : w_pp;
   assign w_addsub = r_op[0] ? {1'b0, r_a} - {1'b0, r_b} : {1'b0, r_a} + {1'b0, r_b};
   assign w_low    = w_addsub[WIDTH-1:0];
   assign w_sovf   = (r_op[0] ? r_a[WIDTH-1] != r_b[WIDTH-1] : r_a[WIDTH-1] == r_b[WIDTH-1])
                     && (w_low[WIDTH-1] != r_a[WIDTH-1]);
   assign w_ovf    = r_state == CALC && !r_op[1] && (r_sign ? w_sovf : w_addsub[WIDTH]);
   assign w_err    = r_state == CALC && r_op == 2'b11;
   assign w_res    = r_state == MUL ? w_prod :
                     r_op == 2'b11 ? '0 :
                     {(r_sign ? {WIDTH{w_low[WIDTH-1]}} : {WIDTH{1'b0}}), w_low};
   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   end
   // next-state: reserved opcodes take the single-cycle path and report error
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = operation == 2'b10 ? MUL : CALC;
         CALC:    w_next = DONE;
         MUL:     if (w_last) w_next = DONE;
         default: w_next = IDLE;
      endcase
   end
   // operand capture, one partial product per MUL cycle on magnitudes, output update on entry to DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_sign      <= 1'b0;
         r_neg       <= 1'b0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         result      <= '0;
         overflow    <= 1'b0;
         error       <= 1'b0;
         displayBits <= disp('0, 1'b0);
      end else begin
         if (r_state == IDLE && start) begin
            r_a      <= op1;
            r_b      <= op2;
            r_op     <= operation;
            r_sign   <= sign;
            r_neg    <= sign && (op1[WIDTH-1] ^ op2[WIDTH-1]);
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_m1};
            r_mplier <= w_m2;
         end else if (r_state == MUL) begin
            r_acc    <= w_pp;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
         end
         if (w_fin) begin
            result      <= w_res;
            overflow    <= w_ovf;
            error       <= w_err;
            displayBits <= disp(w_res, r_sign);
         end
      end
   end
endmodule

// File: tb/tb_alu_seq_display.sv
// tb_alu_seq_display: table, hand-written sequences and random operations checked against an arithmetic model
module tb_alu_seq_display;
   logic             clk, reset, start, sign, busy, done, overflow, error;
   logic [7:0]       op1, op2;
   logic [1:0]       operation;
   logic [15:0]      result;
   logic [0:5][7:0]  displayBits;
   int               n_vec = 0, n_bad = 0;
   typedef struct {
      logic [7:0]  a, b;
      logic [1:0]  op;
      logic        s;
      logic [15:0] r;
      logic        ov, er;
   } vec_t;
   vec_t tbl[12];
   alu_seq_display #(.WIDTH(8), .NUM_DIGITS(6)) dut (
      .clk(clk), .reset(reset), .start(start), .op1(op1), .op2(op2),
      .operation(operation), .sign(sign), .busy(busy), .done(done),
      .result(result), .overflow(overflow), .error(error), .displayBits(displayBits)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   function automatic logic [47:0] dm(input logic [15:0] r, input logic s);
      logic [7:0] hx[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      dm = {6{8'hFF}};
      for (int i = 0; i < 4; i++) dm[47-8*i -: 8] = hx[r[4*i +: 4]];
      dm[7:0] = (s && r[15]) ? 8'hBF : 8'hFF;
   endfunction
   function automatic void model(input logic [7:0] a, b, input logic [1:0] op, input logic s,
                                 output logic [15:0] r, output logic ov, er);
      longint x, y, t;
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      er = op == 2'b11;
      ov = 1'b0;
      r = '0;
      if (op == 2'b10) begin
         t = x * y;
         r = t[15:0];
      end else if (op != 2'b11) begin
         t = op == 2'b00 ? x + y : x - y;
         r = s ? {{8{t[7]}}, t[7:0]} : {8'h00, t[7:0]};
         ov = s ? (t < -128 || t > 127) : (t < 0 || t > 255);
      end
   endfunction
   task automatic run_op(input logic [7:0] a, b, input logic [1:0] op, input logic s, input int poke,
                         input logic [15:0] er_r, input logic e_ov, e_er, input string nm);
      int k, lat;
      bit allb;
      lat = op == 2'b10 ? 9 : 2;
      @(negedge clk);
      op1 = a; op2 = b; operation = op; sign = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      allb = 1'b1;
      while (!done && k < 40) begin
         if (!busy) allb = 1'b0;
         if (k == poke) begin
            start = 1'b1; op1 = ~a; op2 = 8'h11; operation = 2'b00;
         end else begin
            start = 1'b0; op1 = 8'($urandom); op2 = 8'($urandom);
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk({nm, " latency"}, 64'(k), 64'(lat));
      chk({nm, " busy"}, 64'(allb), 64'(1));
      chk({nm, " result"}, 64'(result), 64'(er_r));
      chk({nm, " overflow"}, 64'(overflow), 64'(e_ov));
      chk({nm, " error"}, 64'(error), 64'(e_er));
      chk({nm, " display"}, 64'(displayBits), 64'(dm(er_r, s)));
      @(negedge clk);
      chk({nm, " done_width"}, 64'({done, busy}), 64'(0));
   endtask
   initial begin
      int npulse;
      logic [15:0] mr;
      logic mo, me, ms;
      logic [7:0] ma, mb;
      logic [1:0] mop;
      tbl = '{
         '{8'h03, 8'h01, 2'b00, 1'b0, 16'h0004, 1'b0, 1'b0},
         '{8'h01, 8'hFD, 2'b01, 1'b1, 16'h0004, 1'b0, 1'b0},
         '{8'h7F, 8'h01, 2'b00, 1'b1, 16'hFF80, 1'b1, 1'b0},
         '{8'hFF, 8'hFF, 2'b10, 1'b0, 16'hFE01, 1'b0, 1'b0},
         '{8'hFD, 8'h05, 2'b10, 1'b1, 16'hFFF1, 1'b0, 1'b0},
         '{8'h12, 8'h34, 2'b11, 1'b0, 16'h0000, 1'b0, 1'b1},
         '{8'h05, 8'h06, 2'b00, 1'b0, 16'h000B, 1'b0, 1'b0},
         '{8'hFF, 8'h01, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0},
         '{8'h00, 8'h01, 2'b01, 1'b0, 16'h00FF, 1'b1, 1'b0},
         '{8'h80, 8'h01, 2'b01, 1'b1, 16'h007F, 1'b1, 1'b0},
         '{8'h80, 8'h80, 2'b10, 1'b1, 16'h4000, 1'b0, 1'b0},
         '{8'h80, 8'h7F, 2'b10, 1'b1, 16'hC080, 1'b0, 1'b0}
      };
      reset = 1'b1; start = 1'b0; op1 = '0; op2 = '0; operation = '0; sign = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset busy_done", 64'({busy, done}), 64'(0));
      chk("reset result", 64'({result, overflow, error}), 64'(0));
      chk("reset display", 64'(displayBits), 64'(48'hC0C0C0C0FFFF));
      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].s, 0, tbl[i].r, tbl[i].ov, tbl[i].er, $sformatf("tbl%0d", i));
         if (i == 0) chk("tbl0 digits", 64'(displayBits), 64'(48'h99C0C0C0FFFF));
         if (i == 2) chk("tbl2 digits", 64'(displayBits), 64'(48'hC0808E8EFFBF));
      end
      run_op(8'h0F, 8'h03, 2'b10, 1'b0, 3, 16'h002D, 1'b0, 1'b0, "mul_poke");
      @(negedge clk);
      op1 = 8'h02; op2 = 8'h03; operation = 2'b00; sign = 1'b0; start = 1'b1;
      @(negedge clk);
      chk("hold busy1", 64'({busy, done}), 64'(2'b10));
      @(negedge clk);
      chk("hold done1", 64'({done, result}), 64'({1'b1, 16'h0005}));
      op1 = 8'h10; op2 = 8'h20;
      @(negedge clk);
      chk("hold idle", 64'({busy, done}), 64'(0));
      @(negedge clk);
      chk("hold accept", 64'({busy, done}), 64'(2'b10));
      start = 1'b0;
      @(negedge clk);
      chk("hold done2", 64'({done, result}), 64'({1'b1, 16'h0030}));
      @(negedge clk);
      chk("hold pulse", 64'(done), 64'(0));
      @(negedge clk);
      op1 = 8'hFF; op2 = 8'hFF; operation = 2'b10; sign = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst busy_done", 64'({busy, done}), 64'(0));
      chk("midrst result", 64'(result), 64'(0));
      chk("midrst display", 64'(displayBits), 64'(48'hC0C0C0C0FFFF));
      npulse = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) npulse++;
      end
      chk("midrst no_done", 64'(npulse), 64'(0));
      for (int i = 0; i < 40; i++) begin
         ma = 8'($urandom); mb = 8'($urandom); mop = 2'($urandom); ms = 1'($urandom);
         model(ma, mb, mop, ms, mr, mo, me);
         run_op(ma, mb, mop, ms, $urandom_range(0, 3), mr, mo, me, $sformatf("rnd%0d", i));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
